// File: rtl/trap_ctrl_if.sv
// Commit/CSR/redirect bundle seen by the trap controller.
// Redirect handshake: redirect_pc is held stable while redirect_vld is high; transfer occurs on an edge where redirect_vld && redirect_rdy.
interface trap_ctrl_if #(parameter int XLEN = 64);
  logic            commit_vld;
  logic [7:0]      commit_rob_idx;
  logic [XLEN-1:0] commit_pc;
  logic            commit_has_except;
  logic [15:0]     commit_cause;
  logic [XLEN-1:0] commit_tval;
  logic            commit_mret;
  logic [15:0]     mip_en;
  logic            mstatus_mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] cur_mepc;
  logic            busy;
  logic            flush;
  logic [7:0]      flush_rob_idx;
  logic            csr_we;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mtval;
  logic            redirect_vld;
  logic            redirect_rdy;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  commit_vld, commit_rob_idx, commit_pc, commit_has_except, commit_cause,
           commit_tval, commit_mret, mip_en, mstatus_mie, mtvec, cur_mepc, redirect_rdy,
    output busy, flush, flush_rob_idx, csr_we, mcause, mepc, mtval, redirect_vld, redirect_pc
  );

  modport master (
    output commit_vld, commit_rob_idx, commit_pc, commit_has_except, commit_cause,
           commit_tval, commit_mret, mip_en, mstatus_mie, mtvec, cur_mepc, redirect_rdy,
    input  busy, flush, flush_rob_idx, csr_we, mcause, mepc, mtval, redirect_vld, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-side trap controller: picks interrupt / exception / mret at the oldest commit
// and sequences flush, machine-trap CSR write and fetch redirect.
module trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, FLUSH, CSRWR, REDIRECT} state_e;

  state_e          state;
  logic            is_mret;
  logic            irq_take;
  logic            trigger;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] trap_target;

  // Machine-level sources first, then supervisor; any other set bit falls back to the lowest index.
  always_comb begin
    irq_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (bus.mip_en[i]) irq_code = i[3:0];
    end
    if      (bus.mip_en[11]) irq_code = 4'd11;
    else if (bus.mip_en[3])  irq_code = 4'd3;
    else if (bus.mip_en[7])  irq_code = 4'd7;
    else if (bus.mip_en[9])  irq_code = 4'd9;
    else if (bus.mip_en[1])  irq_code = 4'd1;
    else if (bus.mip_en[5])  irq_code = 4'd5;
  end

  assign irq_take    = bus.commit_vld & bus.mstatus_mie & (|bus.mip_en);
  assign trigger     = irq_take | (bus.commit_vld & (bus.commit_has_except | bus.commit_mret));
  assign vec_base    = {bus.mtvec[XLEN-1:2], 2'b00};
  assign trap_target = (irq_take && bus.mtvec[1:0] == 2'b01)
                     ? vec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                     : vec_base;

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      is_mret           <= 1'b0;
      bus.flush         <= 1'b0;
      bus.flush_rob_idx <= 8'd0;
      bus.csr_we        <= 1'b0;
      bus.mcause        <= '0;
      bus.mepc          <= '0;
      bus.mtval         <= '0;
      bus.redirect_vld  <= 1'b0;
      bus.redirect_pc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state             <= FLUSH;
            bus.flush         <= 1'b1;
            bus.flush_rob_idx <= bus.commit_rob_idx;
            if (irq_take) begin
              is_mret         <= 1'b0;
              bus.mcause      <= {1'b1, {(XLEN-17){1'b0}}, 12'd0, irq_code};
              bus.mepc        <= bus.commit_pc;
              bus.mtval       <= '0;
              bus.redirect_pc <= trap_target;
            end else if (bus.commit_has_except) begin
              is_mret         <= 1'b0;
              bus.mcause      <= {1'b0, {(XLEN-17){1'b0}}, bus.commit_cause};
              bus.mepc        <= bus.commit_pc;
              bus.mtval       <= bus.commit_tval;
              bus.redirect_pc <= trap_target;
            end else begin
              is_mret         <= 1'b1;
              bus.redirect_pc <= bus.cur_mepc;
            end
          end
        end
        FLUSH: begin
          bus.flush <= 1'b0;
          if (is_mret) begin
            state            <= REDIRECT;
            bus.redirect_vld <= 1'b1;
          end else begin
            state      <= CSRWR;
            bus.csr_we <= 1'b1;
          end
        end
        CSRWR: begin
          bus.csr_we       <= 1'b0;
          state            <= REDIRECT;
          bus.redirect_vld <= 1'b1;
        end
        REDIRECT: begin
          if (bus.redirect_vld && bus.redirect_rdy) begin
            bus.redirect_vld <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized commits checked against a
// rule-level reference model.
module tb_trap_ctrl;
  localparam int XLEN = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  typedef struct packed {
    logic        trig;
    logic        is_mret;
    logic [63:0] cause;
    logic [63:0] epc;
    logic [63:0] tval;
    logic [63:0] target;
  } exp_t;

  // Reference: applies the trigger priority and target rules to the currently driven commit.
  function automatic exp_t model();
    int   prio[6] = '{11, 3, 7, 9, 1, 5};
    int   code;
    exp_t e;
    e = '0;
    if (!bus.commit_vld) return e;
    if (bus.mstatus_mie && bus.mip_en != 16'd0) begin
      code = -1;
      foreach (prio[k]) if (code < 0 && bus.mip_en[prio[k]]) code = prio[k];
      e.trig   = 1'b1;
      e.cause  = 64'h8000_0000_0000_0000 | 64'(code);
      e.epc    = bus.commit_pc;
      e.tval   = 64'd0;
      e.target = (bus.mtvec & ~64'h3) + ((bus.mtvec % 4 == 1) ? 64'(4 * code) : 64'd0);
    end else if (bus.commit_has_except) begin
      e.trig   = 1'b1;
      e.cause  = 64'(bus.commit_cause);
      e.epc    = bus.commit_pc;
      e.tval   = bus.commit_tval;
      e.target = bus.mtvec & ~64'h3;
    end else if (bus.commit_mret) begin
      e.trig    = 1'b1;
      e.is_mret = 1'b1;
      e.target  = bus.cur_mepc;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.commit_vld        = 1'b0;
    bus.commit_rob_idx    = 8'd0;
    bus.commit_pc         = '0;
    bus.commit_has_except = 1'b0;
    bus.commit_cause      = 16'd0;
    bus.commit_tval       = '0;
    bus.commit_mret       = 1'b0;
    bus.mip_en            = 16'd0;
    bus.mstatus_mie       = 1'b0;
    bus.mtvec             = '0;
    bus.cur_mepc          = '0;
    bus.redirect_rdy      = 1'b1;
  endtask

  task automatic drive_random_commit();
    int sbits[6] = '{1, 3, 5, 7, 9, 11};
    bus.commit_vld        = ($urandom_range(0, 99) < 85);
    bus.commit_rob_idx    = 8'($urandom);
    bus.commit_pc         = {$urandom, $urandom};
    bus.commit_has_except = ($urandom_range(0, 2) == 0);
    bus.commit_cause      = 16'($urandom_range(0, 24));
    bus.commit_tval       = {$urandom, $urandom};
    bus.commit_mret       = ($urandom_range(0, 3) == 0);
    bus.mstatus_mie       = 1'($urandom_range(0, 1));
    bus.mip_en            = 16'd0;
    if ($urandom_range(0, 1) == 1)
      foreach (sbits[k]) if ($urandom_range(0, 2) == 0) bus.mip_en[sbits[k]] = 1'b1;
    bus.mtvec             = {$urandom, $urandom};
    bus.cur_mepc          = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if ({bus.busy, bus.flush, bus.flush_rob_idx, bus.csr_we, bus.mcause, bus.mepc, bus.mtval,
         bus.redirect_vld, bus.redirect_pc, dbg_state} !== '0)
      begin failures++; $display("FAIL reset_outputs: busy=%0b flush=%0b idx=%h we=%0b mcause=%h mepc=%h mtval=%h rv=%0b rpc=%h st=%0d, want all 0",
        bus.busy, bus.flush, bus.flush_rob_idx, bus.csr_we, bus.mcause, bus.mepc, bus.mtval, bus.redirect_vld, bus.redirect_pc, dbg_state); end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.redirect_vld !== 1'b0)
      begin failures++; $display("FAIL reset_release_idle: busy=%0b rv=%0b, want 0 0", bus.busy, bus.redirect_vld); end
  endtask

  task automatic test_exception();
    idle_inputs();
    bus.mtvec = 64'h0000_0000_0000_2003;
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b1;
    bus.commit_cause = 16'd2;
    bus.commit_pc = 64'h8000_0000_0000_0010;
    bus.commit_tval = 64'hDEAD;
    bus.commit_rob_idx = 8'h05;
    tick();
    bus.commit_vld = 1'b0;
    checks++;
    if (bus.flush !== 1'b1 || bus.busy !== 1'b1 || bus.flush_rob_idx !== 8'h05 || bus.csr_we !== 1'b0)
      begin failures++; $display("FAIL exc_flush: flush=%0b busy=%0b idx=%h we=%0b, want 1 1 05 0", bus.flush, bus.busy, bus.flush_rob_idx, bus.csr_we); end
    tick();
    checks++;
    if (bus.csr_we !== 1'b1 || bus.flush !== 1'b0 || bus.mcause !== 64'd2 ||
        bus.mepc !== 64'h8000_0000_0000_0010 || bus.mtval !== 64'hDEAD)
      begin failures++; $display("FAIL exc_csr: we=%0b flush=%0b mcause=%h mepc=%h mtval=%h, want 1 0 2 8000000000000010 dead",
        bus.csr_we, bus.flush, bus.mcause, bus.mepc, bus.mtval); end
    tick();
    checks++;
    if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== 64'h2000 || bus.csr_we !== 1'b0)
      begin failures++; $display("FAIL exc_redirect: rv=%0b pc=%h we=%0b, want 1 2000 0", bus.redirect_vld, bus.redirect_pc, bus.csr_we); end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.redirect_vld !== 1'b0)
      begin failures++; $display("FAIL exc_idle: busy=%0b rv=%0b, want 0 0", bus.busy, bus.redirect_vld); end
  endtask

  task automatic test_vectored_irq();
    idle_inputs();
    bus.mtvec = 64'h1001;
    bus.mstatus_mie = 1'b1;
    bus.mip_en = 16'h0880;
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b1;
    bus.commit_cause = 16'd5;
    bus.commit_pc = 64'h8000_0000_0000_0040;
    bus.commit_tval = 64'h1234;
    bus.commit_rob_idx = 8'h11;
    tick();
    bus.commit_vld = 1'b0;
    tick();
    checks++;
    if (bus.csr_we !== 1'b1 || bus.mcause !== 64'h8000_0000_0000_000B || bus.mtval !== 64'd0 ||
        bus.mepc !== 64'h8000_0000_0000_0040)
      begin failures++; $display("FAIL irq_csr: we=%0b mcause=%h mtval=%h mepc=%h, want 1 800000000000000b 0 8000000000000040",
        bus.csr_we, bus.mcause, bus.mtval, bus.mepc); end
    tick();
    checks++;
    if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== 64'h102C)
      begin failures++; $display("FAIL irq_redirect: rv=%0b pc=%h, want 1 102c", bus.redirect_vld, bus.redirect_pc); end
    tick();
  endtask

  task automatic test_mret();
    idle_inputs();
    bus.commit_vld = 1'b1;
    bus.commit_mret = 1'b1;
    bus.cur_mepc = 64'h8000_0000_0000_0100;
    bus.commit_rob_idx = 8'h22;
    tick();
    bus.commit_vld = 1'b0;
    checks++;
    if (bus.flush !== 1'b1 || bus.flush_rob_idx !== 8'h22 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL mret_flush: flush=%0b idx=%h busy=%0b, want 1 22 1", bus.flush, bus.flush_rob_idx, bus.busy); end
    tick();
    checks++;
    if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== 64'h8000_0000_0000_0100 || bus.csr_we !== 1'b0 || bus.flush !== 1'b0)
      begin failures++; $display("FAIL mret_redirect: rv=%0b pc=%h we=%0b flush=%0b, want 1 8000000000000100 0 0",
        bus.redirect_vld, bus.redirect_pc, bus.csr_we, bus.flush); end
    tick();
    checks++;
    if (bus.busy !== 1'b0)
      begin failures++; $display("FAIL mret_idle: busy=%0b, want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.redirect_rdy = 1'b0;
    bus.mtvec = 64'h0000_0000_0000_3000;
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b1;
    bus.commit_cause = 16'd24;
    bus.commit_pc = 64'h4000;
    bus.commit_rob_idx = 8'h33;
    tick();
    bus.commit_vld = 1'b0;
    tick();
    checks++;
    if (bus.mcause !== 64'd24)
      begin failures++; $display("FAIL bp_custom_cause: mcause=%h, want 18", bus.mcause); end
    tick();
    for (int w = 0; w < 5; w++) begin
      bus.commit_vld = 1'b1;
      bus.commit_has_except = 1'b1;
      bus.commit_mret = 1'b1;
      bus.commit_rob_idx = 8'(w + 1);
      bus.mtvec = 64'h9990;
      tick();
      checks++;
      if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== 64'h3000 || bus.busy !== 1'b1 ||
          bus.flush !== 1'b0 || bus.csr_we !== 1'b0 || bus.flush_rob_idx !== 8'h33)
        begin failures++; $display("FAIL bp_hold[%0d]: rv=%0b pc=%h busy=%0b flush=%0b we=%0b idx=%h, want 1 3000 1 0 0 33",
          w, bus.redirect_vld, bus.redirect_pc, bus.busy, bus.flush, bus.csr_we, bus.flush_rob_idx); end
    end
    bus.commit_vld = 1'b0;
    bus.redirect_rdy = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.redirect_vld !== 1'b0)
      begin failures++; $display("FAIL bp_release: busy=%0b rv=%0b, want 0 0", bus.busy, bus.redirect_vld); end
  endtask

  task automatic test_masked();
    idle_inputs();
    bus.mstatus_mie = 1'b0;
    bus.mip_en = 16'h0888;
    bus.commit_vld = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.flush !== 1'b0)
      begin failures++; $display("FAIL masked_irq: busy=%0b flush=%0b, want 0 0", bus.busy, bus.flush); end
    bus.commit_vld = 1'b0;
    bus.commit_has_except = 1'b1;
    bus.commit_mret = 1'b1;
    bus.mstatus_mie = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.flush !== 1'b0)
      begin failures++; $display("FAIL no_commit_vld: busy=%0b flush=%0b, want 0 0", bus.busy, bus.flush); end
    idle_inputs();
  endtask

  task automatic test_rob_wrap();
    idle_inputs();
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b1;
    bus.commit_rob_idx = 8'hFF;
    tick();
    bus.commit_vld = 1'b0;
    checks++;
    if (bus.flush_rob_idx !== 8'hFF || bus.flush !== 1'b1)
      begin failures++; $display("FAIL rob_wrap: idx=%h flush=%0b, want ff 1", bus.flush_rob_idx, bus.flush); end
    tick();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.mtvec = 64'h500;
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b1;
    bus.commit_rob_idx = 8'h40;
    tick();
    bus.commit_vld = 1'b0;
    tick();
    tick();
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b0;
    bus.commit_mret = 1'b1;
    bus.cur_mepc = 64'h7700;
    bus.commit_rob_idx = 8'h41;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.redirect_vld !== 1'b0)
      begin failures++; $display("FAIL b2b_idle_t4: busy=%0b rv=%0b, want 0 0", bus.busy, bus.redirect_vld); end
    tick();
    bus.commit_vld = 1'b0;
    checks++;
    if (bus.flush !== 1'b1 || bus.flush_rob_idx !== 8'h41)
      begin failures++; $display("FAIL b2b_second_flush: flush=%0b idx=%h, want 1 41", bus.flush, bus.flush_rob_idx); end
    tick();
    checks++;
    if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== 64'h7700)
      begin failures++; $display("FAIL b2b_second_redirect: rv=%0b pc=%h, want 1 7700", bus.redirect_vld, bus.redirect_pc); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.mtvec = 64'h600;
    bus.commit_vld = 1'b1;
    bus.commit_has_except = 1'b1;
    bus.commit_tval = 64'hBEEF;
    bus.commit_rob_idx = 8'h09;
    tick();
    bus.commit_vld = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if ({bus.busy, bus.flush, bus.flush_rob_idx, bus.csr_we, bus.mcause, bus.mepc, bus.mtval,
         bus.redirect_vld, bus.redirect_pc, dbg_state} !== '0)
      begin failures++; $display("FAIL reset_mid: busy=%0b flush=%0b idx=%h we=%0b mtval=%h rv=%0b rpc=%h st=%0d, want all 0",
        bus.busy, bus.flush, bus.flush_rob_idx, bus.csr_we, bus.mtval, bus.redirect_vld, bus.redirect_pc, dbg_state); end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.redirect_vld !== 1'b0 || bus.csr_we !== 1'b0)
        begin failures++; $display("FAIL reset_mid_after[%0d]: busy=%0b rv=%0b we=%0b, want 0 0 0", c, bus.busy, bus.redirect_vld, bus.csr_we); end
    end
  endtask

  task automatic test_random();
    exp_t       e;
    logic [7:0] idx;
    int         wait_n;
    for (int n = 0; n < 200; n++) begin
      drive_random_commit();
      bus.redirect_rdy = 1'($urandom_range(0, 1));
      e = model();
      idx = bus.commit_rob_idx;
      tick();
      bus.commit_vld = 1'b0;
      if (!e.trig) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.flush !== 1'b0)
          begin failures++; $display("FAIL rnd_no_trig[%0d]: busy=%0b flush=%0b, want 0 0", n, bus.busy, bus.flush); end
        continue;
      end
      exp_q.push_back(e.target);
      checks++;
      if (bus.flush !== 1'b1 || bus.busy !== 1'b1 || bus.flush_rob_idx !== idx)
        begin failures++; $display("FAIL rnd_flush[%0d]: flush=%0b busy=%0b idx=%h, want 1 1 %h", n, bus.flush, bus.busy, bus.flush_rob_idx, idx); end
      drive_random_commit();
      tick();
      if (!e.is_mret) begin
        checks++;
        if (bus.csr_we !== 1'b1 || bus.flush !== 1'b0 || bus.mcause !== e.cause || bus.mepc !== e.epc || bus.mtval !== e.tval)
          begin failures++; $display("FAIL rnd_csr[%0d]: we=%0b flush=%0b mcause=%h mepc=%h mtval=%h, want 1 0 %h %h %h",
            n, bus.csr_we, bus.flush, bus.mcause, bus.mepc, bus.mtval, e.cause, e.epc, e.tval); end
        drive_random_commit();
        tick();
      end
      checks++;
      if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== exp_q[0] || bus.csr_we !== 1'b0 || bus.flush !== 1'b0)
        begin failures++; $display("FAIL rnd_redirect[%0d]: rv=%0b pc=%h we=%0b flush=%0b, want 1 %h 0 0",
          n, bus.redirect_vld, bus.redirect_pc, bus.csr_we, bus.flush, exp_q[0]); end
      wait_n = $urandom_range(0, 3);
      bus.redirect_rdy = 1'b0;
      for (int w = 0; w < wait_n; w++) begin
        drive_random_commit();
        tick();
        checks++;
        if (bus.redirect_vld !== 1'b1 || bus.redirect_pc !== exp_q[0] || bus.busy !== 1'b1 || bus.flush_rob_idx !== idx)
          begin failures++; $display("FAIL rnd_hold[%0d]: rv=%0b pc=%h busy=%0b idx=%h, want 1 %h 1 %h",
            n, bus.redirect_vld, bus.redirect_pc, bus.busy, bus.flush_rob_idx, exp_q[0], idx); end
      end
      bus.redirect_rdy = 1'b1;
      tick();
      void'(exp_q.pop_front());
      checks++;
      if (bus.busy !== 1'b0 || bus.redirect_vld !== 1'b0)
        begin failures++; $display("FAIL rnd_done[%0d]: busy=%0b rv=%0b, want 0 0", n, bus.busy, bus.redirect_vld); end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    test_reset();
    test_exception();
    test_vectored_irq();
    test_mret();
    test_backpressure();
    test_masked();
    test_rob_wrap();
    test_back_to_back();
    test_reset_mid();
    apply_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Commit-side consumer of the trap encoding (`rv_trap_t::exception` / `rv_trap_t::interrupt`) and of `robIdx_t`. It watches the oldest committing instruction and chooses between three actions: take an exception, take a pending machine interrupt, or execute `mret`. It then runs a fixed sequence: pipeline flush, then machine-trap CSR update, then frontend redirect. It sits between the ROB commit port, the CSR file and the fetch redirect path.

## Interface
- `XLEN`, default 64: data and PC width.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-low reset.
- `i_commit_vld` in 1: the oldest ROB entry is committing this cycle.
- `i_commit_robIdx` in 8 (`robIdx_t`): ROB index of that entry.
- `i_commit_pc` in XLEN: PC of that entry.
- `i_commit_has_except` in 1: the entry carries an exception.
- `i_commit_cause` in 16: exception code, encoded as `rv_trap_t::exception`.
- `i_commit_tval` in XLEN: faulting address or instruction bits.
- `i_commit_mret` in 1: the entry is an `mret`.
- `i_mip_en` in 16: pending interrupts, already ANDed with `mie`. Bit n corresponds to interrupt code n.
- `i_mstatus_mie` in 1: global machine interrupt enable.
- `i_mtvec` in XLEN: trap vector; bits [1:0] are the mode.
- `i_mepc` in XLEN: current `mepc`, used as the `mret` target.
- `o_busy` out 1: high in every state except IDLE.
- `o_flush` out 1: one-cycle flush pulse.
- `o_flush_robIdx` out 8: ROB index of the trapping or `mret` instruction.
- `o_csr_we` out 1: one-cycle write strobe for `mcause`, `mepc` and `mtval`.
- `o_mcause`, `o_mepc`, `o_mtval` out XLEN: values written under `o_csr_we`.
- `o_redirect_vld` out 1: redirect request.
- `i_redirect_rdy` in 1: fetch accepts the redirect.
- `o_redirect_pc` out XLEN: new fetch PC.

## Operation
- **States:** IDLE, FLUSH, CSRWR, REDIRECT.
- **Trigger (IDLE only):** a commit triggers when `i_commit_vld` is high and any of these holds:
  - interrupt take: `i_mstatus_mie` high and `i_mip_en` nonzero;
  - `i_commit_has_except` high;
  - `i_commit_mret` high.
- **Trigger priority:** interrupt, then exception, then `mret`.
- **Commit inputs outside IDLE:** ignored. The ROB must hold commit while `o_busy` is high.
- **Interrupt selection:** code is chosen in the order mExter(11), mSoft(3), mTimer(7), sExter(9), sSoft(1), sTimer(5).
  - `mcause` = {1'b1, 47'b0, code}.
  - `mtval` = 0.
  - `mepc` = `i_commit_pc`; the instruction does not retire.
- **Exception:**
  - `mcause` = {1'b0, 47'b0, `i_commit_cause`}. The cause is passed unchanged, including custom code `badDivisor` (24).
  - `mepc` = `i_commit_pc`.
  - `mtval` = `i_commit_tval`.
- **Trap target:**
  - base = {`i_mtvec`[63:2], 2'b00}.
  - If mode = 1 and the trap is an interrupt, target = base + 4·code. The sum is computed mod 2^64.
  - In every other case (mode 0, 2 or 3, and all exceptions), target = base.
- **mret:** latch `i_mepc` as the target, skip CSRWR, and go FLUSH then REDIRECT.
- **Capture:** all selected values are registered on the trigger edge and stay stable until the state returns to IDLE.
- **Transitions:**
  - IDLE → FLUSH on trigger.
  - FLUSH → CSRWR for a trap, or FLUSH → REDIRECT for `mret`.
  - CSRWR → REDIRECT.
  - REDIRECT → IDLE when `o_redirect_vld` and `i_redirect_rdy` are both high.
  - REDIRECT holds otherwise, with `o_redirect_pc` stable.

## Timing
- **Reset:** state = IDLE. Every output is 0, including `o_mcause`, `o_mepc`, `o_mtval`, `o_redirect_pc` and `o_flush_robIdx`.
- **Reset mid-sequence:** return to IDLE immediately. No partial CSR write or redirect follows deassertion.
- **Trap on edge T:**
  - `o_busy` = 1 from T+1.
  - `o_flush` = 1 during cycle T+1 only.
  - `o_csr_we` = 1 during cycle T+2 only.
  - `o_redirect_vld` = 1 from T+3.
- **mret on edge T:** flush in T+1, `o_redirect_vld` from T+2.
- **Best-case trap:** if `i_redirect_rdy` is already high, IDLE is reached at T+4 and a new trigger is accepted in that cycle.
- **One-cycle outputs:** `o_flush` and `o_csr_we` never stay high for two consecutive cycles.
- **ROB wrap-around:** `o_flush_robIdx` carries the flipped bit unchanged. A trigger at idx 127 with flipped = 1 reports exactly 8'hFF.

## Test plan
- **Exception:** reset, then commit `instIllegal` (2) with pc = 0x8000_0000_0000_0010, tval = 0xDEAD, robIdx = 8'h05 → `o_flush` at T+1 with idx 05. At T+2: `mcause` = 2, `mepc` = 0x…10, `mtval` = 0xDEAD. At T+3: redirect to `i_mtvec` & ~3.
- **Vectored interrupt beats exception:** mtvec = 0x1001 (mode 1), mie = 1, `i_mip_en` = 0x0880 (mTimer and mExter), same commit also has `loadFault` → `mcause` = 0x8000_0000_0000_000B, `mtval` = 0, redirect pc = 0x102C.
- **mret:** commit with `i_commit_mret` = 1 and `i_mepc` = 0x8000_0000_0000_0100 → flush at T+1, no `o_csr_we`, redirect 0x…0100 at T+2.
- **Backpressure:** hold `i_redirect_rdy` = 0 for 5 cycles after the redirect asserts → `o_redirect_vld` and `o_redirect_pc` stay stable, `o_busy` stays 1, and commits applied meanwhile are ignored. Raising rdy returns to IDLE on the next edge.
- **Masked interrupt and reset mid-sequence:**
  - `i_mstatus_mie` = 0 with `i_mip_en` nonzero and a normal commit → no trigger.
  - Assert `rst` during CSRWR → all outputs 0 and state IDLE, with no redirect after release.
